// File: rtl/dcache_responder_pkg.sv
// -----------------------------------------------------------------------------
// dcache_responder_pkg
// Shared definitions for the data-cache responder:
//   - cache geometry (lines, index/tag widths, block and block-address widths)
//   - FUNCT3 load/store size codes
//   - FSM state encoding
// -----------------------------------------------------------------------------
package dcache_responder_pkg;

    localparam int LINES      = 64;
    localparam int IDX_W      = 6;                 // log2(LINES)
    localparam int TAG_W      = 32 - IDX_W - 4;    // 16-byte block
    localparam int BLOCK_W    = 128;               // 4 x 32-bit words
    localparam int BLK_ADDR_W = 28;                // ADDRESS[31:4]

    localparam logic [2:0] F3_B  = 3'b000;         // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;         // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;         // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;         // LBU
    localparam logic [2:0] F3_HU = 3'b101;         // LHU

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_UPDATE    = 2'd3
    } state_t;

endpackage

// File: rtl/dcache_lane_align.sv
// -----------------------------------------------------------------------------
// dcache_lane_align
// Combinational byte-lane handling for one 32-bit cache word.
//   funct3      in   3   access size / signedness
//   byte_off    in   2   ADDRESS[1:0]
//   rd_word     in   32  word currently held in the cache line
//   wr_data     in   32  right-aligned store data
//   load_data   out  32  extracted and sign/zero-extended load result
//   merged_word out  32  rd_word with the store lanes replaced
// Bits of byte_off below the access size are ignored (no misalignment support).
// -----------------------------------------------------------------------------
module dcache_lane_align
    import dcache_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [3:0]  byte_en;
    logic [31:0] lane_data;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a value held (latch).
    always_comb begin
        sel_byte  = rd_word[{byte_off, 3'b000} +: 8];
        sel_half  = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = rd_word;
        endcase
    end

    // Store data is replicated across all lanes; byte_en picks which land.
    always_comb begin
        byte_en   = 4'b1111;
        lane_data = wr_data;
        case (funct3)
            F3_B: begin
                byte_en   = 4'b0001 << byte_off;
                lane_data = {4{wr_data[7:0]}};
            end
            F3_H: begin
                byte_en   = byte_off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wr_data[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                lane_data = wr_data;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged_word[i*8 +: 8] = byte_en[i] ? lane_data[i*8 +: 8] : rd_word[i*8 +: 8];
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// -----------------------------------------------------------------------------
// dcache_responder
// Direct-mapped, write-back, write-allocate data cache (64 lines x 16 bytes)
// between the CPU MEM stage and a 128-bit block memory.
//   CLK, RESET            clock, synchronous active-high reset
//   READ, WRITE, FUNCT3   CPU request (held while BUSYWAIT=1; WRITE wins)
//   ADDRESS, WRITEDATA    CPU byte address and right-aligned store data
//   READDATA, BUSYWAIT    load result (same-cycle on hit), CPU stall
//   MEM_READ, MEM_WRITE   registered block fetch / write-back requests
//   MEM_ADDRESS           block address
//   MEM_WRITEDATA         victim block
//   MEM_READDATA          fetched block
//   MEM_BUSYWAIT          memory transaction in progress
// -----------------------------------------------------------------------------
module dcache_responder
    import dcache_responder_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [2:0]            FUNCT3,
    input  logic [31:0]           ADDRESS,
    input  logic [31:0]           WRITEDATA,
    output logic [31:0]           READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [BLK_ADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    logic [BLOCK_W-1:0]    data_mem [LINES];
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;

    state_t                state_q, next_state;
    logic                  mem_read_q, mem_write_q;
    logic                  mem_read_d, mem_write_d;
    logic [BLK_ADDR_W-1:0] miss_blk_q;   // block that missed; survives a dropped request
    logic [BLOCK_W-1:0]    fill_q;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [1:0]            word_sel;
    logic [IDX_W-1:0]      miss_idx;
    logic                  req, in_idle, hit, store_hit;
    logic [BLOCK_W-1:0]    cur_line, merged_line;
    logic [31:0]           cur_word, load_data, merged_word;

    assign req_tag  = ADDRESS[31:10];
    assign req_idx  = ADDRESS[9:4];
    assign word_sel = ADDRESS[3:2];
    assign miss_idx = miss_blk_q[IDX_W-1:0];

    assign req       = READ || WRITE;
    assign in_idle   = (state_q == ST_IDLE);
    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign store_hit = in_idle && WRITE && hit;

    assign cur_line = data_mem[req_idx];
    assign cur_word = cur_line[{word_sel, 5'b00000} +: 32];

    dcache_lane_align u_align (
        .funct3      (FUNCT3),
        .byte_off    (ADDRESS[1:0]),
        .rd_word     (cur_word),
        .wr_data     (WRITEDATA),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        merged_line = cur_line;
        merged_line[{word_sel, 5'b00000} +: 32] = merged_word;
    end

    // ---------------- state register and control flags ----------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= next_state;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            if (state_q == ST_UPDATE) begin
                valid_q[miss_idx] <= 1'b1;
                dirty_q[miss_idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_q[req_idx]  <= 1'b1;
            end
        end
    end

    // NOTE: data/tag arrays and datapath captures carry no reset; valid_q
    // gates every use of them, which keeps the arrays plain RAM.
    always_ff @(posedge CLK) begin
        if (in_idle && req && !hit) begin
            miss_blk_q <= ADDRESS[31:4];
        end
        if (state_q == ST_ALLOCATE && !MEM_BUSYWAIT) begin
            fill_q <= MEM_READDATA;
        end
        if (state_q == ST_UPDATE && !RESET) begin
            data_mem[miss_idx] <= fill_q;
            tag_mem[miss_idx]  <= miss_blk_q[BLK_ADDR_W-1:IDX_W];
        end else if (store_hit && !RESET) begin
            data_mem[req_idx]  <= merged_line;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE:      if (req && !hit) next_state = dirty_q[req_idx] ? ST_WRITEBACK : ST_ALLOCATE;
            ST_WRITEBACK: if (!MEM_BUSYWAIT) next_state = ST_ALLOCATE;
            ST_ALLOCATE:  if (!MEM_BUSYWAIT) next_state = ST_UPDATE;
            ST_UPDATE:    next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // MEM_READ/MEM_WRITE are registered from next_state, so they rise with
    // the state they belong to and drop the cycle after MEM_BUSYWAIT falls.
    always_comb begin
        mem_read_d    = (next_state == ST_ALLOCATE);
        mem_write_d   = (next_state == ST_WRITEBACK);
        BUSYWAIT      = !RESET && req && !(in_idle && hit);
        READDATA      = (in_idle && READ && !WRITE && hit) ? load_data : 32'd0;
        MEM_ADDRESS   = (state_q == ST_WRITEBACK) ? {tag_mem[miss_idx], miss_idx} : miss_blk_q;
        MEM_WRITEDATA = data_mem[miss_idx];
    end

    assign MEM_READ  = mem_read_q;
    assign MEM_WRITE = mem_write_q;

endmodule

// File: tb/tb_dcache_responder.sv
// -----------------------------------------------------------------------------
// tb_dcache_responder
// Directed stimulus against dcache_responder with a 5-cycle block memory model.
// Expected load results, fetch addresses and write-back blocks are queued when
// stimulus is issued; a negedge monitor pops and compares whenever the DUT
// completes a load or starts a memory transaction.
// -----------------------------------------------------------------------------
module tb_dcache_responder;
    import dcache_responder_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd = 1'b0, wr = 1'b0;
    logic [2:0]   f3 = 3'b000;
    logic [31:0]  addr = '0, wdata = '0;
    logic [31:0]  rdata;
    logic         busy;
    logic         mem_rd, mem_wr;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_busy;

    always #5 clk = ~clk;

    dcache_responder dut (
        .CLK           (clk),
        .RESET         (rst),
        .READ          (rd),
        .WRITE         (wr),
        .FUNCT3        (f3),
        .ADDRESS       (addr),
        .WRITEDATA     (wdata),
        .READDATA      (rdata),
        .BUSYWAIT      (busy),
        .MEM_READ      (mem_rd),
        .MEM_WRITE     (mem_wr),
        .MEM_ADDRESS   (mem_addr),
        .MEM_WRITEDATA (mem_wdata),
        .MEM_READDATA  (mem_rdata),
        .MEM_BUSYWAIT  (mem_busy)
    );

    // ---------------- block memory model: busy for 5 cycles per access ----------------
    logic [127:0] mem_blocks [256];
    int           mem_cnt = 0;

    assign mem_busy  = (mem_rd || mem_wr) && (mem_cnt < 5);
    assign mem_rdata = mem_blocks[mem_addr[7:0]];

    always @(posedge clk) begin
        if (!(mem_rd || mem_wr)) begin
            mem_cnt <= 0;
        end else if (mem_busy) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
            if (mem_wr) mem_blocks[mem_addr[7:0]] <= mem_wdata;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    typedef struct { string name; logic [31:0] value; } load_exp_t;
    typedef struct { logic [27:0] blk; logic [127:0] data; } wb_exp_t;

    load_exp_t   load_q [$];
    logic [27:0] fetch_q [$];
    wb_exp_t     wb_q [$];

    logic prev_mem_rd = 1'b0, prev_mem_wr = 1'b0;

    always @(negedge clk) begin
        if (rd && !wr && !busy && !rst) begin
            check("load queue nonempty", 128'(load_q.size() > 0), 128'd1);
            if (load_q.size() > 0) begin
                load_exp_t e;
                e = load_q.pop_front();
                check(e.name, rdata, e.value);
            end
        end
        if (mem_rd && !prev_mem_rd) begin
            check("mem_read/mem_write exclusive", mem_wr, 1'b0);
            check("fetch queue nonempty", 128'(fetch_q.size() > 0), 128'd1);
            if (fetch_q.size() > 0) check("fetch address", mem_addr, fetch_q.pop_front());
        end
        if (mem_wr && !prev_mem_wr) begin
            check("write-back queue nonempty", 128'(wb_q.size() > 0), 128'd1);
            if (wb_q.size() > 0) begin
                wb_exp_t w;
                w = wb_q.pop_front();
                check("write-back address", mem_addr, w.blk);
                check("write-back block", mem_wdata, w.data);
            end
        end
        prev_mem_rd <= mem_rd;
        prev_mem_wr <= mem_wr;
    end

    // ---------------- stimulus helpers ----------------
    // Holds the request until BUSYWAIT is low at a negedge; busy_cycles counts stalled cycles.
    task automatic access(input logic r, input logic w, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] d, output int busy_cycles);
        @(posedge clk); #1;
        rd = r; wr = w; f3 = fn; addr = a; wdata = d;
        busy_cycles = 0;
        @(negedge clk);
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        if (busy_cycles >= 100) check("request timeout", busy, 1'b0);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic do_load(input string name, input logic [2:0] fn, input logic [31:0] a,
                           input logic [31:0] expv, input int exp_busy);
        int n;
        load_q.push_back('{name: name, value: expv});
        access(1'b1, 1'b0, fn, a, 32'd0, n);
        check({name, " stall cycles"}, 128'(n), 128'(exp_busy));
    endtask

    task automatic do_store(input string name, input logic [2:0] fn, input logic [31:0] a,
                            input logic [31:0] d, input int exp_busy);
        int n;
        access(1'b0, 1'b1, fn, a, d, n);
        check({name, " stall cycles"}, 128'(n), 128'(exp_busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem_blocks[i] = {4{24'h0, 8'(i)}};
        mem_blocks[8'h10] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        mem_blocks[8'h50] = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'hCAFE_F00D};
        mem_blocks[8'h90] = {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'hA1B2_C3D4};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset READDATA",  rdata,  32'd0);
        check("reset BUSYWAIT",  busy,   1'b0);
        check("reset MEM_READ",  mem_rd, 1'b0);
        check("reset MEM_WRITE", mem_wr, 1'b0);

        // 1. cold miss, clean allocate
        fetch_q.push_back(28'h0000010);
        do_load("LW 0x100 cold miss", F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 8);
        // 2. hit
        do_load("LW 0x100 hit", F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 0);
        // 3. byte stores and sized loads
        do_store("SB 0x101", F3_B, 32'h0000_0101, 32'h0000_0055, 0);
        do_load("LW 0x100 after SB", F3_W,  32'h0000_0100, 32'hDEAD_55EF, 0);
        do_load("LB 0x101",          F3_B,  32'h0000_0101, 32'h0000_0055, 0);
        do_store("SB 0x102", F3_B, 32'h0000_0102, 32'h0000_0080, 0);
        do_load("LB 0x102",          F3_B,  32'h0000_0102, 32'hFFFF_FF80, 0);
        do_load("LBU 0x102",         F3_BU, 32'h0000_0102, 32'h0000_0080, 0);
        do_load("LH 0x102",          F3_H,  32'h0000_0102, 32'hFFFF_DE80, 0);
        do_load("LHU 0x100",         F3_HU, 32'h0000_0100, 32'h0000_55EF, 0);

        // 4. dirty conflict miss: write-back then allocate
        wb_q.push_back('{blk: 28'h0000010,
                         data: {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDE80_55EF}});
        fetch_q.push_back(28'h0000050);
        do_load("LW 0x500 dirty miss", F3_W, 32'h0000_0500, 32'hCAFE_F00D, 14);

        // 5. store miss on clean line, then the merged line must be dirty
        fetch_q.push_back(28'h0000090);
        do_store("SH 0x902 miss", F3_H, 32'h0000_0902, 32'h0000_1234, 8);
        do_load("LW 0x900", F3_W, 32'h0000_0900, 32'h1234_C3D4, 0);
        do_load("LH 0x902", F3_H, 32'h0000_0902, 32'h0000_1234, 0);
        wb_q.push_back('{blk: 28'h0000090,
                         data: {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h1234_C3D4}});
        fetch_q.push_back(28'h0000010);
        do_load("LW 0x100 refetch", F3_W, 32'h0000_0100, 32'hDE80_55EF, 14);

        // READ and WRITE together behave as a store
        access(1'b1, 1'b1, F3_W, 32'h0000_0104, 32'h0BAD_F00D, n);
        check("READ+WRITE stall cycles", 128'(n), 128'd0);
        do_load("LW 0x104 after READ+WRITE", F3_W, 32'h0000_0104, 32'h0BAD_F00D, 0);

        // 6. reset during ALLOCATE
        fetch_q.push_back(28'h0000020);
        @(posedge clk); #1;
        rd = 1'b1; f3 = F3_W; addr = 32'h0000_0200;
        @(negedge clk);
        check("miss BUSYWAIT in request cycle", busy, 1'b1);
        n = 0;
        while (!mem_rd && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("reached ALLOCATE", mem_rd, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; rd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("MEM_READ after reset", mem_rd, 1'b0);
        check("BUSYWAIT after reset", busy, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // previously-hit line was invalidated: clean miss, the lost store is gone
        fetch_q.push_back(28'h0000010);
        do_load("LW 0x104 after reset", F3_W, 32'h0000_0104, 32'h1111_1111, 8);

        repeat (3) @(posedge clk);
        check("load queue drained",       128'(load_q.size()),  128'd0);
        check("fetch queue drained",      128'(fetch_q.size()), 128'd0);
        check("write-back queue drained", 128'(wb_q.size()),    128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
